// File: rtl/gf_pow_ctrl.sv
// rtl/gf_pow_ctrl.sv - GF(2^M_P) exponentiation by MSB-first square-and-multiply
module gf_pow_ctrl #(
    parameter int             M_P  = 8,
    parameter logic [M_P-1:0] POLY = 8'h1B
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [M_P-1:0] req_base,
    input  logic [M_P-1:0] req_exp,
    input  logic           req_inv,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [M_P-1:0] rsp_data,
    output logic           rsp_zinv,
    output logic           busy
);

    localparam int KW = (M_P > 1) ? $clog2(M_P) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(M_P - 1);
    // Fermat inverse exponent 2^M_P - 2: all ones with the LSB clear.
    localparam logic [M_P-1:0] INV_EXP = {{(M_P-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQR  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [M_P-1:0]  r_acc;
    logic [M_P-1:0]  r_base;
    logic [M_P-1:0]  r_exp;
    logic [KW-1:0]   r_k;
    logic            r_zinv;
    logic            r_req_ready;
    logic            r_rsp_valid;

    logic [M_P-1:0]  w_op_b;
    logic [M_P-1:0]  w_prod;
    logic [M_P-1:0]  w_acc_nxt;
    logic [KW-1:0]   w_k_nxt;
    logic            w_accept;
    logic            w_rsp_hs;

    // Horner-style product: shift/reduce once per bit of b, MSB first.
    function automatic logic [M_P-1:0] gf_mul(input logic [M_P-1:0] a,
                                              input logic [M_P-1:0] b);
        logic [M_P-1:0] p;
        p = '0;
        for (int i = M_P - 1; i >= 0; i--) begin
            p = {p[M_P-2:0], 1'b0} ^ (p[M_P-1] ? POLY : '0);
            if (b[i]) begin
                p = p ^ a;
            end
        end
        return p;
    endfunction

    assign w_op_b   = (r_state == S_MUL) ? r_base : r_acc;
    assign w_prod   = gf_mul(r_acc, w_op_b);
    assign w_accept = (r_state == S_IDLE) && req_valid && r_req_ready;
    assign w_rsp_hs = (r_state == S_DONE) && rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SQR;
                    w_acc_nxt   = {{(M_P-1){1'b0}}, 1'b1};
                    w_k_nxt     = K_TOP;
                end
            end
            S_SQR: begin
                w_acc_nxt = w_prod;
                if (r_exp[r_k]) begin
                    w_state_nxt = S_MUL;
                end else if (r_k == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_k_nxt = r_k - 1'b1;
                end
            end
            S_MUL: begin
                w_acc_nxt = w_prod;
                if (r_k == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_k_nxt     = r_k - 1'b1;
                    w_state_nxt = S_SQR;
                end
            end
            S_DONE: begin
                if (w_rsp_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake flags are registered from the next state so no output
    // depends combinationally on req_* or rsp_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_k         <= '0;
            r_base      <= '0;
            r_exp       <= '0;
            r_zinv      <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_k         <= w_k_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_base <= req_base;
                r_exp  <= req_inv ? INV_EXP : req_exp;
                r_zinv <= req_inv && (req_base == '0);
            end else if (w_rsp_hs) begin
                r_zinv <= 1'b0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_acc;
    assign rsp_zinv  = r_zinv;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gf_pow_ctrl.sv
// tb/tb_gf_pow_ctrl.sv - directed bench for gf_pow_ctrl
module tb_gf_pow_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_base;
    logic [7:0] req_exp;
    logic       req_inv;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zinv;
    logic       busy;

    int total = 0;
    int bad   = 0;

    gf_pow_ctrl #(.M_P(8), .POLY(8'h1B)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_base  (req_base),
        .req_exp   (req_exp),
        .req_inv   (req_inv),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zinv  (rsp_zinv),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge, then scramble the inputs.
    task automatic start_req(input logic [7:0] b, input logic [7:0] e, input logic inv);
        @(negedge clk);
        req_valid = 1'b1;
        req_base  = b;
        req_exp   = e;
        req_inv   = inv;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_base  = 8'($urandom);
        req_exp   = 8'($urandom);
        req_inv   = 1'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if ({req_ready, rsp_valid, rsp_data, rsp_zinv, busy} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h zinv=%b busy=%b want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_zinv, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] vb [6] = '{8'h53, 8'h02, 8'h02, 8'h03, 8'h00, 8'h57};
        logic [7:0] ve [6] = '{8'h00, 8'h07, 8'h08, 8'hFF, 8'h00, 8'h02};
        logic       vi [6] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
        logic [7:0] vr [6] = '{8'hCA, 8'h80, 8'h1B, 8'h01, 8'h01, 8'hA5};
        int         vl [6] = '{15,    11,    9,     16,    8,     9};
        int lat;
        for (int i = 0; i < 6; i++) begin
            start_req(vb[i], ve[i], vi[i]);
            total++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL vec%0d_busy: got rdy=%b busy=%b want 0/1", i, req_ready, busy);
            end
            wait_rsp(lat);
            total++;
            if (lat !== vl[i]) begin
                bad++;
                $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vl[i]);
            end
            total++;
            if (rsp_data !== vr[i] || rsp_zinv !== 1'b0) begin
                bad++;
                $display("FAIL vec%0d_data: got %h zinv=%b want %h zinv=0", i, rsp_data, rsp_zinv, vr[i]);
            end
            ack_rsp();
        end
    endtask

    task automatic test_zero_inverse();
        int lat;
        start_req(8'h00, 8'h33, 1'b1);
        wait_rsp(lat);
        total++;
        if (lat !== 15 || rsp_data !== 8'h00 || rsp_zinv !== 1'b1) begin
            bad++;
            $display("FAIL zero_inverse: got lat=%0d data=%h zinv=%b want 15/00/1", lat, rsp_data, rsp_zinv);
        end
        ack_rsp();
        start_req(8'h00, 8'h05, 1'b0);
        wait_rsp(lat);
        total++;
        if (lat !== 10 || rsp_data !== 8'h00 || rsp_zinv !== 1'b0) begin
            bad++;
            $display("FAIL zero_pow: got lat=%0d data=%h zinv=%b want 10/00/0", lat, rsp_data, rsp_zinv);
        end
        ack_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        int errs = 0;
        start_req(8'h02, 8'h02, 1'b0);
        wait_rsp(lat);
        total++;
        if (rsp_data !== 8'h04) begin
            bad++;
            $display("FAIL bp_data: got %h want 04", rsp_data);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h04 || req_ready !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", errs);
        end
        ack_rsp();
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_reready: got rdy=%b vld=%b busy=%b want 1/0/0", req_ready, rsp_valid, busy);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen = 0;
        start_req(8'h53, 8'h00, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_data, rsp_zinv, busy} !== 12'h000) begin
            bad++;
            $display("FAIL midrst_outputs: got rdy=%b vld=%b data=%h zinv=%b busy=%b want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_zinv, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrst_no_rsp: got %0d valid cycles want 0", seen);
        end
        start_req(8'h53, 8'h00, 1'b1);
        wait_rsp(lat);
        total++;
        if (lat !== 15 || rsp_data !== 8'hCA) begin
            bad++;
            $display("FAIL midrst_after: got lat=%0d data=%h want 15/ca", lat, rsp_data);
        end
        ack_rsp();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_base  = 8'h00;
        req_exp   = 8'h00;
        req_inv   = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_vectors();
        test_zero_inverse();
        test_backpressure();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
